// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with a one-entry skid buffer. The head feeds MEM and the forwarding unit,
// the skid entry absorbs one extra instruction. Optional stall counter: define EX_MEM_STALL_CNT_EN.
module ex_mem_skid_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ex_alu_result,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_write_reg,
  input  logic              ex_reg_write,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] exMem_alu_result,
  output logic [DATA_W-1:0] exMem_store_data,
  output logic [REG_W-1:0]  exMem_write_reg,
  output logic              exMem_reg_write,
  output logic              exMem_mem_read,
  output logic              exMem_mem_write,
  input  logic [REG_W-1:0]  decode_read_reg1,
  input  logic [REG_W-1:0]  decode_read_reg2,
  output logic              skid_hazard
`ifdef EX_MEM_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cycles
`endif
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  write_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } entry_t;

  logic   r_hv;
  logic   r_sv;
  entry_t r_head;
  entry_t r_skid;

  logic   w_hv_nxt;
  logic   w_sv_nxt;
  entry_t w_head_nxt;
  entry_t w_skid_nxt;
  entry_t w_in;
  logic   w_accept;
  logic   w_drain;

  assign w_in = {ex_alu_result, ex_store_data, ex_write_reg,
                 ex_reg_write, ex_mem_read, ex_mem_write};

  // ex_ready depends only on the skid valid bit, never on mem_ready
  assign ex_ready = ~r_sv;
  assign w_accept = ex_valid & ~r_sv;
  assign w_drain  = r_hv & mem_ready;

  // next-state: flush first, then skid move, then head load / skid fill
  always_comb begin
    w_hv_nxt   = r_hv;
    w_sv_nxt   = r_sv;
    w_head_nxt = r_head;
    w_skid_nxt = r_skid;
    if (flush) begin
      w_hv_nxt = 1'b0;
      w_sv_nxt = 1'b0;
    end else if (r_sv) begin
      if (w_drain) begin
        w_head_nxt = r_skid;
        w_sv_nxt   = 1'b0;
      end
    end else if (!r_hv || w_drain) begin
      if (w_accept) begin
        w_head_nxt = w_in;
        w_hv_nxt   = 1'b1;
      end else begin
        w_hv_nxt   = 1'b0;
      end
    end else if (w_accept) begin
      w_skid_nxt = w_in;
      w_sv_nxt   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hv   <= 1'b0;
      r_sv   <= 1'b0;
      r_head <= '0;
      r_skid <= '0;
    end else begin
      r_hv   <= w_hv_nxt;
      r_sv   <= w_sv_nxt;
      r_head <= w_head_nxt;
      r_skid <= w_skid_nxt;
    end
  end

  assign mem_valid        = r_hv;
  assign exMem_alu_result = r_head.alu_result;
  assign exMem_store_data = r_head.store_data;
  assign exMem_write_reg  = r_head.write_reg;
  assign exMem_reg_write  = r_hv & r_head.reg_write;
  assign exMem_mem_read   = r_hv & r_head.mem_read;
  assign exMem_mem_write  = r_hv & r_head.mem_write;

  // forwarding only sees the head, so a parked skid producer must stall decode
  assign skid_hazard = r_sv & r_skid.reg_write & (r_skid.write_reg != REG_W'(0)) &
                       ((r_skid.write_reg == decode_read_reg1) |
                        (r_skid.write_reg == decode_read_reg2));

`ifdef EX_MEM_STALL_CNT_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0] r_stall_cnt;

  // saturating count of cycles MEM holds a valid head; only rst_n clears it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_hv && !mem_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench for ex_mem_skid_reg: directed stimulus pushes expected entries,
// a negedge monitor pops and compares each one MEM consumes.
module tb_ex_mem_skid_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_write_reg;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] exMem_alu_result;
  logic [31:0] exMem_store_data;
  logic [4:0]  exMem_write_reg;
  logic        exMem_reg_write;
  logic        exMem_mem_read;
  logic        exMem_mem_write;
  logic [4:0]  decode_read_reg1;
  logic [4:0]  decode_read_reg2;
  logic        skid_hazard;
`ifdef EX_MEM_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  ex_mem_skid_reg #(.DATA_W(32), .REG_W(5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .ex_valid         (ex_valid),
    .ex_ready         (ex_ready),
    .ex_alu_result    (ex_alu_result),
    .ex_store_data    (ex_store_data),
    .ex_write_reg     (ex_write_reg),
    .ex_reg_write     (ex_reg_write),
    .ex_mem_read      (ex_mem_read),
    .ex_mem_write     (ex_mem_write),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .exMem_alu_result (exMem_alu_result),
    .exMem_store_data (exMem_store_data),
    .exMem_write_reg  (exMem_write_reg),
    .exMem_reg_write  (exMem_reg_write),
    .exMem_mem_read   (exMem_mem_read),
    .exMem_mem_write  (exMem_mem_write),
    .decode_read_reg1 (decode_read_reg1),
    .decode_read_reg2 (decode_read_reg2),
    .skid_hazard      (skid_hazard)
`ifdef EX_MEM_STALL_CNT_EN
    ,
    .stall_cycles     (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   n_drain  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every head MEM consumes must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_valid === 1'b1 && mem_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_unexpected: got alu 0x%0h expected no output at %0t",
                 exMem_alu_result, $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_drain++;
        check("mon_alu", 64'(exMem_alu_result), 64'(e.alu));
        check("mon_sd",  64'(exMem_store_data), 64'(e.sd));
        check("mon_wr",  64'(exMem_write_reg),  64'(e.wr));
        check("mon_ctl", 64'({exMem_reg_write, exMem_mem_read, exMem_mem_write}),
              64'({e.rw, e.mr, e.mw}));
      end
    end else if (rst_n === 1'b1 && mem_valid === 1'b0) begin
      check("mon_ctl_qual", 64'({exMem_reg_write, exMem_mem_read, exMem_mem_write}), 64'(0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid      = 1'b0;
    ex_alu_result = '0;
    ex_store_data = '0;
    ex_write_reg  = '0;
    ex_reg_write  = 1'b0;
    ex_mem_read   = 1'b0;
    ex_mem_write  = 1'b0;
  endtask

  task automatic offer(input logic [31:0] alu, input logic [4:0] wr, input logic rw,
                       input logic mr, input logic mw, input bit expect_accept);
    exp_t e;
    ex_valid      = 1'b1;
    ex_alu_result = alu;
    ex_store_data = alu ^ 32'h5A5A_0000;
    ex_write_reg  = wr;
    ex_reg_write  = rw;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    e = '{alu: alu, sd: alu ^ 32'h5A5A_0000, wr: wr, rw: rw, mr: mr, mw: mw};
    if (expect_accept) q.push_back(e);
  endtask

  int base;

  initial begin
    rst_n = 1'b1; flush = 1'b0; mem_ready = 1'b0;
    decode_read_reg1 = '0; decode_read_reg2 = '0;
    idle();
    #3 rst_n = 1'b0;
    #1;
    check("rst_mem_valid", 64'(mem_valid), 64'(0));
    check("rst_ex_ready", 64'(ex_ready), 64'(1));
    check("rst_fields", 64'({exMem_alu_result, exMem_write_reg, exMem_reg_write}), 64'(0));
    check("rst_hazard", 64'(skid_hazard), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", 64'(ex_ready), 64'(1));
    check("post_rst_valid", 64'(mem_valid), 64'(0));

    // streaming, mem_ready held high
    mem_ready = 1'b1;
    base = n_drain;
    for (int i = 0; i < 4; i++) begin
      offer(32'h10 * 32'(i + 1), 5'(i + 1), 1'b1, 1'b0, 1'b0, 1'b1);
      check("stream_ready", 64'(ex_ready), 64'(1));
      tick();
      check("stream_valid", 64'(mem_valid), 64'(1));
    end
    idle();
    tick();
    check("stream_empty", 64'(mem_valid), 64'(0));
    check("stream_count", 64'(n_drain - base), 64'(4));

    // skid fill and drain
    mem_ready = 1'b0;
    offer(32'hA, 5'd3, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("skid_h_only_ready", 64'(ex_ready), 64'(1));
    check("skid_head_a", 64'(exMem_alu_result), 64'hA);
    offer(32'hB, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check("skid_full_ready", 64'(ex_ready), 64'(0));
    offer(32'hC, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("skid_hold_ready", 64'(ex_ready), 64'(0));
    check("skid_hold_head", 64'(exMem_alu_result), 64'hA);
    check("skid_hold_wr", 64'(exMem_write_reg), 64'd3);
    check("skid_hold_ctl", 64'({exMem_reg_write, exMem_mem_read, exMem_mem_write}), 64'b110);
    idle();
    mem_ready = 1'b1;
    tick();
    check("skid_move_ready", 64'(ex_ready), 64'(1));
    check("skid_move_head", 64'(exMem_alu_result), 64'hB);
    tick();
    check("skid_drained", 64'(mem_valid), 64'(0));
    mem_ready = 1'b0;

    // skid hazard: write_reg 7 parked in S
    offer(32'h50, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    offer(32'h70, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    decode_read_reg1 = 5'd1; decode_read_reg2 = 5'd7;
    #1 check("haz_rs2", 64'(skid_hazard), 64'(1));
    decode_read_reg2 = 5'd4;
    #1 check("haz_none", 64'(skid_hazard), 64'(0));
    decode_read_reg1 = 5'd7;
    #1 check("haz_rs1", 64'(skid_hazard), 64'(1));
    decode_read_reg1 = 5'd5; decode_read_reg2 = 5'd0;
    #1 check("haz_head_dest", 64'(skid_hazard), 64'(0));
    mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    offer(32'h51, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    offer(32'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    decode_read_reg1 = 5'd0; decode_read_reg2 = 5'd0;
    #1 check("haz_r0", 64'(skid_hazard), 64'(0));
    mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    offer(32'h52, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    offer(32'h90, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    tick();
    idle();
    decode_read_reg1 = 5'd9;
    #1 check("haz_no_rw", 64'(skid_hazard), 64'(0));
    mem_ready = 1'b1;
    tick(); tick();
    mem_ready = 1'b0;
    check("haz_q_empty", 64'(q.size()), 64'(0));

    // flush with both entries full and a new instruction offered
    offer(32'hE1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    offer(32'hE2, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    decode_read_reg1 = 5'd12;
    #1 check("flush_pre_haz", 64'(skid_hazard), 64'(1));
    offer(32'hE3, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    q.delete();
    check("flush_valid", 64'(mem_valid), 64'(0));
    check("flush_ready", 64'(ex_ready), 64'(1));
    check("flush_haz", 64'(skid_hazard), 64'(0));
    // flush while empty discards the offered instruction
    offer(32'hE4, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    check("flush_empty_valid", 64'(mem_valid), 64'(0));
    mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;

    // asynchronous reset mid-stream
    offer(32'hF1, 5'd15, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    offer(32'hF2, 5'd16, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    decode_read_reg1 = 5'd16;
    #1 check("mid_pre_haz", 64'(skid_hazard), 64'(1));
    check("mid_pre_valid", 64'(mem_valid), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check("mid_valid", 64'(mem_valid), 64'(0));
    check("mid_rw", 64'(exMem_reg_write), 64'(0));
    check("mid_haz", 64'(skid_hazard), 64'(0));
    check("mid_ready", 64'(ex_ready), 64'(1));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("mid_post_ready", 64'(ex_ready), 64'(1));
    check("mid_post_valid", 64'(mem_valid), 64'(0));

`ifdef EX_MEM_STALL_CNT_EN
    check("cnt_reset", 64'(stall_cycles), 64'(0));
    offer(32'hC0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    repeat (5) tick();
    check("cnt_five", 64'(stall_cycles), 64'(5));
    repeat (70000) @(posedge clk);
    #1 check("cnt_sat", 64'(stall_cycles), 64'hFFFF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
    tick();
    check("cnt_flush_keep", 64'(stall_cycles), 64'hFFFF);
`endif

    check("final_q_empty", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- EX/MEM pipeline boundary register with a one-entry skid buffer. Decouples a stalling memory stage from the execute stage.
- Captures the EX result and control bits and presents them to the MEM stage.
- Drives the exMem_reg_write / exMem_write_reg pair consumed by the forwarding unit.
- Flags decode-stage hazards against an instruction parked in the skid entry, which forwarding cannot see.

Parameters:
- DATA_W, 32, width of ALU result and store data
- REG_W, 5, register-specifier width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill all held instructions (branch/exception redirect)
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  block can accept this cycle
- ex_alu_result  in  DATA_W  ALU result / memory address
- ex_store_data  in  DATA_W  store data
- ex_write_reg  in  REG_W  destination register
- ex_reg_write  in  1  instruction writes the register file
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- mem_valid  out  1  head entry valid
- mem_ready  in  1  MEM consumes head this cycle
- exMem_alu_result  out  DATA_W  head ALU result
- exMem_store_data  out  DATA_W  head store data
- exMem_write_reg  out  REG_W  head destination
- exMem_reg_write  out  1  head reg_write, qualified by mem_valid
- exMem_mem_read  out  1  head load, qualified by mem_valid
- exMem_mem_write  out  1  head store, qualified by mem_valid
- decode_read_reg1  in  REG_W  decode source 1
- decode_read_reg2  in  REG_W  decode source 2
- skid_hazard  out  1  decode source matches a skid-entry destination

Behaviour:
- State: head entry H with valid bit hv; skid entry S with valid bit sv. Data fields are plain flops; only the valid bits matter functionally.
- Reset (rst_n low, asynchronous):
  - hv=0, sv=0, all data fields 0.
  - Therefore mem_valid=0, exMem_* all 0, skid_hazard=0, ex_ready=1 one reset-release later. ex_ready is combinationally 1 while in reset.
- ex_ready = ~sv. It depends on state only, with no combinational path from mem_ready.
- Definitions: accept = ex_valid & ex_ready; drain = hv & mem_ready.
- Next state, with flush taking priority:
  - flush=1: hv<=0, sv<=0. Any EX instruction offered that cycle is discarded. A drain occurring that cycle is still seen by MEM, since mem_valid is high during that cycle.
  - sv=0, hv=0: accept loads H, hv<=1.
  - sv=0, hv=1, drain: accept loads H (hv stays 1); no accept sets hv<=0.
  - sv=0, hv=1, no drain: accept loads S, sv<=1. This is the skid case.
  - sv=1: no accept is possible. Drain moves S into H and sets sv<=0 (hv stays 1). No drain holds both entries.
- Latency: one cycle from accept to mem_valid when empty. Throughput is one per cycle while mem_ready stays high.
- Ordering: strict FIFO order is preserved; S is always younger than H.
- Head fields are stable while mem_valid=1 and mem_ready=0.
- exMem_reg_write, exMem_mem_read and exMem_mem_write are 0 whenever hv=0.
- exMem_write_reg, exMem_alu_result and exMem_store_data show the raw H contents.
- Register 0 destinations pass through unmodified; the forwarding unit masks them.
- skid_hazard = sv & S.reg_write & (S.write_reg != 0) & (S.write_reg == decode_read_reg1 or S.write_reg == decode_read_reg2). It is combinational from state and decode inputs.

Optional Feature:
- Macro EX_MEM_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles [15:0].
  - Increments once per cycle with hv & ~mem_ready.
  - Saturates at 16'hFFFF.
  - Cleared only by rst_n; unaffected by flush.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset mid-stream: hv=sv=1, assert rst_n low asynchronously -> mem_valid, exMem_reg_write, skid_hazard go 0 immediately; ex_ready=1 after release.
- Streaming with mem_ready=1: 4 back-to-back instructions, alu_result 0x10,0x20,0x30,0x40 -> mem_valid high from cycle 1; outputs appear in order, one per cycle; ex_ready never drops.
- Skid fill/drain:
  - Setup: mem_ready=0; offer A (alu_result 0xA, write_reg 3), then B (alu_result 0xB, write_reg 4).
  - Required response: H=A and S=B; ex_ready=0 while mem_ready stays low; head stays A.
  - Then raise mem_ready -> A consumed, then B on the next cycle; ex_ready returns to 1 after the move.
- Skid hazard:
  - Setup: S holds write_reg 7 with reg_write=1; decode_read_reg2=7.
  - Required response: skid_hazard=1.
  - Variants: write_reg 0, or reg_write=0 -> skid_hazard=0.
- Flush with ex_valid=1 and both entries full -> next cycle mem_valid=0, sv=0; the offered instruction never appears at MEM.
- Counter, with EX_MEM_STALL_CNT_EN defined: hold hv=1 with mem_ready=0 for 70000 cycles -> stall_cycles=16'hFFFF, no wrap.
